// File: rtl/recirculador_param_if.sv
// Recirculator lane bus: lane words/valids in, recirc and fwd outputs back.
// slave = recirculator side, master = source/sink side.
interface recirculador_param_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
`ifdef RECIRC_STATS_EN
  , parameter int CNT_W = 16
`endif
);
  logic [LANES*DATA_W-1:0] data_in;
  logic [LANES-1:0]        valid_in;
  logic                    active_req;
  logic                    fwd_ready;
  logic [LANES*DATA_W-1:0] recirc_data;
  logic [LANES-1:0]        recirc_valid;
  logic [LANES*DATA_W-1:0] fwd_data;
  logic [LANES-1:0]        fwd_valid;
  logic                    route_fwd;
  logic                    bp_recirc;
`ifdef RECIRC_STATS_EN
  logic [LANES*CNT_W-1:0]  recirc_count;
`endif

  modport slave (
    input  data_in, valid_in, active_req, fwd_ready,
    output recirc_data, recirc_valid, fwd_data, fwd_valid,
    output route_fwd, bp_recirc
`ifdef RECIRC_STATS_EN
    , output recirc_count
`endif
  );

  modport master (
    output data_in, valid_in, active_req, fwd_ready,
    input  recirc_data, recirc_valid, fwd_data, fwd_valid,
    input  route_fwd, bp_recirc
`ifdef RECIRC_STATS_EN
    , input recirc_count
`endif
  );
endinterface

// File: rtl/recirculador_param.sv
// N-lane recirculator: routes valid lane words to recirc or fwd outputs,
// registered, with debounced word-aligned mode switch and backpressure.
// Ports: clk, reset_L (async active-low), bus (recirculador_param_if.slave).
// Option: RECIRC_STATS_EN builds per-lane recirc counters (recirc_count).
module recirculador_param #(
  parameter int LANES       = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_CYCLES = 2
`ifdef RECIRC_STATS_EN
  , parameter int CNT_W     = 16
`endif
) (
  input logic                 clk,
  input logic                 reset_L,
  recirculador_param_if.slave bus
);
  localparam int CW = $clog2(SYNC_CYCLES + 1);
  localparam logic [CW-1:0] SYNC_LIM = CW'(SYNC_CYCLES);
  localparam int W = LANES * DATA_W;

  typedef enum logic [1:0] {
    S_RECIRC,
    S_ARM_FWD,
    S_FORWARD,
    S_ARM_RECIRC
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            uniform, route, to_fwd;
  logic [W-1:0]    masked;
  logic [W-1:0]    rd_q, rd_d, fd_q, fd_d;
  logic [LANES-1:0] rv_q, rv_d, fv_q, fv_d;
  logic            route_q, route_d, bp_q, bp_d;

  assign uniform = (bus.valid_in == '0) ||
                   (bus.valid_in == '1);

  // Count saturates so a long alignment wait cannot wrap.
  assign cnt_inc = (cnt_q >= SYNC_LIM) ? cnt_q
                                       : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RECIRC: begin
        if (bus.active_req) begin
          if (SYNC_CYCLES == 1 && uniform) begin
            state_d = S_FORWARD;
            cnt_d   = '0;
          end else begin
            state_d = S_ARM_FWD;
            cnt_d   = CW'(1);
          end
        end
      end
      S_ARM_FWD: begin
        if (!bus.active_req) begin
          state_d = S_RECIRC;
          cnt_d   = '0;
        end else if (cnt_inc >= SYNC_LIM && uniform) begin
          state_d = S_FORWARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_FORWARD: begin
        if (!bus.active_req) begin
          if (SYNC_CYCLES == 1 && uniform) begin
            state_d = S_RECIRC;
            cnt_d   = '0;
          end else begin
            state_d = S_ARM_RECIRC;
            cnt_d   = CW'(1);
          end
        end
      end
      S_ARM_RECIRC: begin
        if (bus.active_req) begin
          state_d = S_FORWARD;
          cnt_d   = '0;
        end else if (cnt_inc >= SYNC_LIM && uniform) begin
          state_d = S_RECIRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_RECIRC;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    masked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.valid_in[i]) begin
        masked[i*DATA_W +: DATA_W] =
          bus.data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Routing uses the pre-edge state; a stalled fwd cycle
  // falls back to the recirc path.
  assign route  = (state_q == S_FORWARD) ||
                  (state_q == S_ARM_RECIRC);
  assign to_fwd = route && bus.fwd_ready;

  always_comb begin
    rv_d    = to_fwd ? '0 : bus.valid_in;
    rd_d    = to_fwd ? '0 : masked;
    fv_d    = to_fwd ? bus.valid_in : '0;
    fd_d    = to_fwd ? masked : '0;
    bp_d    = route && !bus.fwd_ready &&
              (|bus.valid_in);
    route_d = (state_d == S_FORWARD) ||
              (state_d == S_ARM_RECIRC);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_RECIRC;
      cnt_q   <= '0;
      rv_q    <= '0;
      rd_q    <= '0;
      fv_q    <= '0;
      fd_q    <= '0;
      route_q <= 1'b0;
      bp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      fv_q    <= fv_d;
      fd_q    <= fd_d;
      route_q <= route_d;
      bp_q    <= bp_d;
    end
  end

  assign bus.recirc_valid = rv_q;
  assign bus.recirc_data  = rd_q;
  assign bus.fwd_valid    = fv_q;
  assign bus.fwd_data     = fd_q;
  assign bus.route_fwd    = route_q;
  assign bus.bp_recirc    = bp_q;

`ifdef RECIRC_STATS_EN
  logic [LANES*CNT_W-1:0] st_q, st_d;

  always_comb begin
    st_d = st_q;
    for (int i = 0; i < LANES; i++) begin
      if (rv_d[i] && !(&st_q[i*CNT_W +: CNT_W])) begin
        st_d[i*CNT_W +: CNT_W] =
          st_q[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign bus.recirc_count = st_q;
`endif
endmodule
